ic_hc_actab_arbiter: RTL and testbench

IC_HC_ACTAB_ARBITER -- requirements
Module: ic_hc_actab_arbiter

---
 rtl/ic_hc_pkg.sv | 16 +
 rtl/ic_hc_rr_arb.sv | 42 ++++
 rtl/ic_hc_actab_arbiter.sv | 78 +++++++
 tb/tb_ic_hc_actab_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ic_hc_pkg.sv
// Shared Huffman-coding definitions: AC table ROM geometry and table word layout.
package ic_hc_pkg;

    localparam int unsigned HC_ROM_DEPTH = 161;
    localparam int unsigned HC_ROM_AW    = 8;
    localparam int unsigned HC_ROM_DW    = 21;
    localparam int unsigned HC_LEN_W     = 5;
    localparam int unsigned HC_CODE_W    = HC_ROM_DW - HC_LEN_W;

    // One AC table word: code length in the top bits, right-aligned code bits below.
    typedef struct packed {
        logic [HC_LEN_W-1:0]  code_len;
        logic [HC_CODE_W-1:0] code_bits;
    } hc_word_t;

endpackage

// File: rtl/ic_hc_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr upward, wrapping modulo NUM_REQ.
module ic_hc_rr_arb #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant_c,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_c,
    output logic                       grant_any_c
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] idx;

    // First requesting index at or after rr_ptr wins; nothing is granted while in reset.
    always_comb begin
        grant_c     = '0;
        grant_id_c  = '0;
        grant_any_c = 1'b0;
        idx         = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = IDW'((32'(rr_ptr) + off) % NUM_REQ);
            if (!grant_any_c && req[idx] && reset_n) begin
                grant_c[idx] = 1'b1;
                grant_id_c   = idx;
                grant_any_c  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (grant_any_c) begin
            rr_ptr <= (grant_id_c == IDW'(NUM_REQ - 1)) ? '0 : grant_id_c + IDW'(1);
        end
    end

endmodule

// File: rtl/ic_hc_actab_arbiter.sv
// Shares one external AC Huffman table ROM among NUM_REQ requesters; one lookup per
// cycle, responses two cycles after grant, tagged with requester id and range error.
module ic_hc_actab_arbiter
    import ic_hc_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ROM_DEPTH = HC_ROM_DEPTH,
    parameter int unsigned ROM_AW    = HC_ROM_AW,
    parameter int unsigned ROM_DW    = HC_ROM_DW
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ROM_AW-1:0]  req_addr,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [ROM_AW-1:0]          rom_address,
    input  logic [ROM_DW-1:0]          rom_q,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [ROM_DW-1:0]          resp_q,
    output logic                       resp_err,
    output logic                       busy
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    logic [IDW-1:0]    grant_id;
    logic              grant_any;
    logic [ROM_AW-1:0] sel_addr;
    logic              sel_err;
    logic [ROM_AW-1:0] last_addr;
    logic              s1_valid;
    logic [IDW-1:0]    s1_id;
    logic              s1_err;

    ic_hc_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .clk         (clock),
        .reset_n     (reset_n),
        .req         (req_valid),
        .grant_c     (req_ready),
        .grant_id_c  (grant_id),
        .grant_any_c (grant_any)
    );

    assign sel_addr    = req_addr[32'(grant_id)*ROM_AW +: ROM_AW];
    assign sel_err     = 32'(sel_addr) >= ROM_DEPTH;
    // The ROM registers its address every cycle, so idle cycles re-present the last lookup.
    assign rom_address = grant_any ? sel_addr : last_addr;
    assign busy        = s1_valid | resp_valid;

    // Stage 1 carries the tag while the ROM read is in flight; stage 2 captures rom_q.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_addr  <= '0;
            s1_valid   <= 1'b0;
            s1_id      <= '0;
            s1_err     <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
            resp_q     <= '0;
        end else begin
            if (grant_any) begin
                last_addr <= sel_addr;
            end
            s1_valid   <= grant_any;
            s1_id      <= grant_id;
            s1_err     <= grant_any & sel_err;
            resp_valid <= s1_valid;
            resp_id    <= s1_id;
            resp_err   <= s1_valid & s1_err;
            resp_q     <= (s1_valid && !s1_err) ? rom_q : '0;
        end
    end

endmodule

// File: tb/tb_ic_hc_actab_arbiter.sv
// Table-driven bench for ic_hc_actab_arbiter with a behavioral registered ROM.
module tb_ic_hc_actab_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 21;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   rom_address;
    logic [DW-1:0]   rom_q = '0;
    logic            resp_valid;
    logic [1:0]      resp_id;
    logic [DW-1:0]   resp_q;
    logic            resp_err;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          rst;
        logic [3:0]  v;
        logic [31:0] addr;
        logic [3:0]  er;
        logic [7:0]  ea;
    } vec_t;

    typedef struct {
        bit         v;
        logic [1:0] id;
        bit         err;
        logic [7:0] a;
    } tag_t;

    vec_t tbl[$];
    tag_t e1, e2;

    ic_hc_actab_arbiter #(
        .NUM_REQ   (N),
        .ROM_DEPTH (161),
        .ROM_AW    (AW),
        .ROM_DW    (DW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_q      (resp_q),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] rom_word(input logic [7:0] a);
        return {5'(a[4:0] ^ 5'h15), a, ~a};
    endfunction

    always @(posedge clock) rom_q <= rom_word(rom_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input bit rst, input logic [3:0] v, input logic [31:0] addr,
                                input logic [3:0] er, input logic [7:0] ea);
        vec_t r;
        r.rst = rst; r.v = v; r.addr = addr; r.er = er; r.ea = ea;
        tbl.push_back(r);
    endfunction

    // Drive one row, check grant/address and the response owed from two rows back.
    task automatic step(input vec_t r);
        int k;
        @(negedge clock);
        reset_n   = !r.rst;
        req_valid = r.v;
        req_addr  = r.addr;
        #1;
        chk("req_ready", 32'(req_ready), 32'(r.er));
        chk("rom_address", 32'(rom_address), 32'(r.ea));
        chk("busy", 32'(busy), 32'(e1.v | e2.v));
        chk("resp_valid", 32'(resp_valid), 32'(e2.v));
        if (e2.v) begin
            chk("resp_id", 32'(resp_id), 32'(e2.id));
            chk("resp_err", 32'(resp_err), 32'(e2.err));
            chk("resp_q", 32'(resp_q), e2.err ? 32'd0 : 32'(rom_word(e2.a)));
        end
        if (r.rst) begin
            e1 = '{v: 1'b0, id: 2'd0, err: 1'b0, a: 8'd0};
            e2 = e1;
        end else begin
            e2 = e1;
            k = 0;
            for (int i = 0; i < 4; i++) if (r.er[i]) k = i;
            e1.v   = (r.er != 4'b0);
            e1.id  = 2'(k);
            e1.a   = r.addr[k*8 +: 8];
            e1.err = (e1.a >= 8'd161);
        end
    endtask

    initial begin
        logic [3:0] seen;
        e1 = '{v: 1'b0, id: 2'd0, err: 1'b0, a: 8'd0};
        e2 = e1;

        // Single lookup, then ten idle cycles with junk addresses (rom_address must hold).
        add(0, 4'b0001, 32'h00000005, 4'b0001, 8'h05);
        for (int i = 0; i < 10; i++) add(0, 4'b0000, 32'h77665544, 4'b0000, 8'h05);
        // All four valid: rr_ptr left at 1 by the first grant.
        for (int i = 0; i < 2; i++) begin
            add(0, 4'b1111, 32'h13121110, 4'b0010, 8'h11);
            add(0, 4'b1111, 32'h13121110, 4'b0100, 8'h12);
            add(0, 4'b1111, 32'h13121110, 4'b1000, 8'h13);
            add(0, 4'b1111, 32'h13121110, 4'b0001, 8'h10);
        end
        // Fairness between requesters 1 and 3.
        for (int i = 0; i < 2; i++) begin
            add(0, 4'b1010, 32'h23222120, 4'b0010, 8'h21);
            add(0, 4'b1010, 32'h23222120, 4'b1000, 8'h23);
        end
        // Range boundary: 161 and 255 error, 160 is the last valid word.
        add(0, 4'b0100, 32'h00A10000, 4'b0100, 8'hA1);
        add(0, 4'b0100, 32'h00FF0000, 4'b0100, 8'hFF);
        add(0, 4'b0100, 32'h00A00000, 4'b0100, 8'hA0);
        add(0, 4'b0000, 32'h00000000, 4'b0000, 8'hA0);
        add(0, 4'b0000, 32'h00000000, 4'b0000, 8'hA0);
        // Reset with two lookups in flight; afterwards lowest valid index wins.
        add(0, 4'b0001, 32'h00000030, 4'b0001, 8'h30);
        add(0, 4'b0010, 32'h00003100, 4'b0010, 8'h31);
        add(1, 4'b1100, 32'h41400000, 4'b0000, 8'h31);
        add(0, 4'b0000, 32'h41400000, 4'b0000, 8'h00);
        add(0, 4'b1100, 32'h41400000, 4'b0100, 8'h40);
        add(0, 4'b1100, 32'h41400000, 4'b1000, 8'h41);
        for (int i = 0; i < 3; i++) add(0, 4'b0000, 32'h00000000, 4'b0000, 8'h41);

        // Reset state with every requester asserting.
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        req_addr  = 32'h44332211;
        @(negedge clock);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rom_address", 32'(rom_address), 32'd0);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_id", 32'(resp_id), 32'd0);
        chk("reset resp_q", 32'(resp_q), 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);

        foreach (tbl[i]) step(tbl[i]);

        // Every requester of a fully loaded set is served within NUM_REQ cycles.
        seen = '0;
        for (int c = 0; c < N; c++) begin
            @(negedge clock);
            req_valid = 4'b1111;
            req_addr  = 32'h03020100;
            #1;
            chk("onehot grant", 32'($onehot(req_ready)), 32'd1);
            seen = seen | req_ready;
        end
        chk("all served within NUM_REQ", 32'(seen), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
